// File: rtl/instr_alu_exec.sv
// Fetch/decode/ALU slice of the single-cycle CPU with registered result and flags.
// Optional ILLEGAL_OP_TRAP_EN: flag undecodable instructions and freeze results on a sticky trap.
module instr_alu_exec #(
  parameter int unsigned IMEM_AW = 6
) (
  input  logic               CLK,
  input  logic               Reset_L,
  input  logic [31:0]        pc,
  input  logic               imem_we,
  input  logic [IMEM_AW-1:0] imem_waddr,
  input  logic [31:0]        imem_wdata,
  input  logic [31:0]        bus_a,
  input  logic [31:0]        bus_b,
  input  logic               carry_in,
  input  logic               exec_en,
  output logic [31:0]        instruction,
  output logic [3:0]         alu_op,
  output logic [31:0]        alu_out,
  output logic               overflow,
  output logic               carry_out,
  output logic               zero,
  output logic [31:0]        result_q,
  output logic [2:0]         flags_q,
  output logic               illegal
);

  localparam int unsigned DEPTH = 1 << IMEM_AW;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_ADDU = 4'b1000;
  localparam logic [3:0] OP_SUBU = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_LUI  = 4'b1110;

  logic [31:0] mem [DEPTH];
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        dec_illegal;
  logic        capture;
  logic [32:0] sum_add;
  logic [32:0] sum_sub;
  logic        unused_bits;

  // Instruction memory: synchronous write, asynchronous word-aligned read that wraps modulo depth
  always_ff @(posedge CLK) begin
    if (imem_we) mem[imem_waddr] <= imem_wdata;
  end

  assign instruction = mem[pc[IMEM_AW+1:2]];
  assign opcode      = instruction[31:26];
  assign funct       = instruction[5:0];

  // ALU-control decode; anything unrecognised falls back to ADD
  always_comb begin
    alu_op      = OP_ADD;
    dec_illegal = 1'b0;
    if (opcode == 6'h00) begin
      case (funct)
        6'h20:   alu_op = OP_ADD;
        6'h21:   alu_op = OP_ADDU;
        6'h22:   alu_op = OP_SUB;
        6'h23:   alu_op = OP_SUBU;
        6'h24:   alu_op = OP_AND;
        6'h25:   alu_op = OP_OR;
        6'h26:   alu_op = OP_XOR;
        6'h27:   alu_op = OP_NOR;
        6'h2A:   alu_op = OP_SLT;
        6'h2B:   alu_op = OP_SLTU;
        6'h00:   alu_op = OP_SLL;
        6'h02:   alu_op = OP_SRL;
        6'h03:   alu_op = OP_SRA;
        default: dec_illegal = 1'b1;
      endcase
    end else begin
      case (opcode)
        6'h08, 6'h23, 6'h2B: alu_op = OP_ADD;
        6'h09:               alu_op = OP_ADDU;
        6'h0C:               alu_op = OP_AND;
        6'h0D:               alu_op = OP_OR;
        6'h0E:               alu_op = OP_XOR;
        6'h0A:               alu_op = OP_SLT;
        6'h0B:               alu_op = OP_SLTU;
        6'h0F:               alu_op = OP_LUI;
        6'h04, 6'h05:        alu_op = OP_SUB;
        default:             dec_illegal = 1'b1;
      endcase
    end
  end

  assign sum_add = {1'b0, bus_a} + {1'b0, bus_b} + {32'd0, carry_in};
  assign sum_sub = {1'b0, bus_a} + {1'b0, ~bus_b} + 33'd1;

  // Behavioural ALU; carry/overflow stay low for non-arithmetic ops
  always_comb begin
    alu_out   = 32'd0;
    carry_out = 1'b0;
    overflow  = 1'b0;
    case (alu_op)
      OP_ADD: begin
        {carry_out, alu_out} = sum_add;
        overflow = (bus_a[31] == bus_b[31]) && (sum_add[31] != bus_a[31]);
      end
      OP_ADDU: {carry_out, alu_out} = sum_add;
      OP_SUB: begin
        {carry_out, alu_out} = sum_sub;
        overflow = (bus_a[31] != bus_b[31]) && (sum_sub[31] != bus_a[31]);
      end
      OP_SUBU: {carry_out, alu_out} = sum_sub;
      OP_AND:  alu_out = bus_a & bus_b;
      OP_OR:   alu_out = bus_a | bus_b;
      OP_XOR:  alu_out = bus_a ^ bus_b;
      OP_NOR:  alu_out = ~(bus_a | bus_b);
      OP_SLT:  alu_out = {31'd0, $signed(bus_a) < $signed(bus_b)};
      OP_SLTU: alu_out = {31'd0, bus_a < bus_b};
      OP_SLL:  alu_out = bus_b << bus_a[4:0];
      OP_SRL:  alu_out = bus_b >> bus_a[4:0];
      OP_SRA:  alu_out = 32'($signed(bus_b) >>> bus_a[4:0]);
      OP_LUI:  alu_out = {bus_b[15:0], 16'h0000};
      default: alu_out = 32'd0;
    endcase
  end

  assign zero = (alu_out == 32'd0);

`ifdef ILLEGAL_OP_TRAP_EN
  logic sticky;

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L)                       sticky <= 1'b0;
    else if (exec_en && dec_illegal)    sticky <= 1'b1;
  end

  assign capture     = exec_en && !sticky;
  assign illegal     = dec_illegal | sticky;
  assign unused_bits = ^{pc[31:IMEM_AW+2], pc[1:0], instruction[25:6]};
`else
  assign capture     = exec_en;
  assign illegal     = 1'b0;
  assign unused_bits = ^{pc[31:IMEM_AW+2], pc[1:0], instruction[25:6], dec_illegal};
`endif

  // Result/flag capture stage
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      result_q <= 32'd0;
      flags_q  <= 3'd0;
    end else if (capture) begin
      result_q <= alu_out;
      flags_q  <= {overflow, carry_out, zero};
    end
  end

endmodule

// File: tb/tb_instr_alu_exec.sv
// Scoreboard bench for instr_alu_exec: stimulus pushes expectations, a monitor pops and compares.
module tb_instr_alu_exec;

  localparam int unsigned IMEM_AW = 6;
`ifdef ILLEGAL_OP_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic               CLK = 1'b0;
  logic               Reset_L;
  logic [31:0]        pc;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_waddr;
  logic [31:0]        imem_wdata;
  logic [31:0]        bus_a, bus_b;
  logic               carry_in, exec_en;
  logic [31:0]        instruction, alu_out, result_q;
  logic [3:0]         alu_op;
  logic               overflow, carry_out, zero, illegal;
  logic [2:0]         flags_q;

  instr_alu_exec #(.IMEM_AW(IMEM_AW)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .pc(pc), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .bus_a(bus_a),
    .bus_b(bus_b), .carry_in(carry_in), .exec_en(exec_en),
    .instruction(instruction), .alu_op(alu_op), .alu_out(alu_out),
    .overflow(overflow), .carry_out(carry_out), .zero(zero),
    .result_q(result_q), .flags_q(flags_q), .illegal(illegal)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  op;
    logic [31:0] res;
    logic [2:0]  fl;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic issued   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Load the instruction at pc, then issue one enabled execute cycle
  task automatic apply(input logic [31:0] p, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input logic ci, input logic [3:0] op,
                       input logic [31:0] res, input logic [2:0] fl, input logic ill);
    exp_t e;
    imem_we    = 1'b1;
    imem_waddr = IMEM_AW'(p >> 2);
    imem_wdata = ins;
    @(posedge CLK); #1;
    imem_we  = 1'b0;
    pc       = p;
    bus_a    = a;
    bus_b    = b;
    carry_in = ci;
    exec_en  = 1'b1;
    issued   = 1'b1;
    e.instr = ins; e.op = op; e.res = res; e.fl = fl; e.ill = ill;
    exp_q.push_back(e);
    @(posedge CLK); #1;
    exec_en = 1'b0;
    issued  = 1'b0;
  endtask

  // Monitor: combinational outputs mid-cycle, registered outputs just after the capture edge
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (issued) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("instruction", instruction, e.instr);
          chk("alu_op", 32'(alu_op), 32'(e.op));
          chk("alu_out", alu_out, e.res);
          chk("flags_comb", 32'({overflow, carry_out, zero}), 32'(e.fl));
          chk("illegal", 32'(illegal), 32'(e.ill));
          @(posedge CLK); #1;
          chk("result_q", result_q, e.res);
          chk("flags_q", 32'(flags_q), 32'(e.fl));
        end
      end
    end
  end

  initial begin
    Reset_L = 1'b0; pc = 32'd0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = 32'd0;
    bus_a = 32'd0; bus_b = 32'd0; carry_in = 1'b0; exec_en = 1'b0;
    #2;
    chk("reset_result_q", result_q, 32'd0);
    chk("reset_flags_q", 32'(flags_q), 32'd0);
    #12 Reset_L = 1'b1;
    @(posedge CLK); #1;

    //     pc     instr         A             B             ci  op     result        flags   ill
    apply(32'h00, 32'h00221820, 32'd5,        32'd7,        0, 4'h2, 32'd12,       3'b000, 0);
    apply(32'h04, 32'h00221822, 32'h80000000, 32'd1,        0, 4'h6, 32'h7FFFFFFF, 3'b110, 0);
    apply(32'h08, 32'h00221823, 32'h80000000, 32'd1,        0, 4'h9, 32'h7FFFFFFF, 3'b010, 0);
    apply(32'h0C, 32'h0022182A, 32'hFFFFFFFF, 32'd1,        0, 4'h7, 32'd1,        3'b000, 0);
    apply(32'h10, 32'h0022182B, 32'hFFFFFFFF, 32'd1,        0, 4'hB, 32'd0,        3'b001, 0);
    apply(32'h14, 32'h00221803, 32'd4,        32'h80000000, 0, 4'hD, 32'hF8000000, 3'b000, 0);
    apply(32'h18, 32'h3C011234, 32'd0,        32'h00001234, 0, 4'hE, 32'h12340000, 3'b000, 0);
    apply(32'h1C, 32'h10220003, 32'd9,        32'd9,        0, 4'h6, 32'd0,        3'b011, 0);
    apply(32'h20, 32'h20220001, 32'hFFFFFFFF, 32'd0,        1, 4'h2, 32'd0,        3'b011, 0);
    apply(32'h24, 32'h00221820, 32'h7FFFFFFF, 32'd1,        0, 4'h2, 32'h80000000, 3'b100, 0);
    apply(32'h28, 32'h24220001, 32'h7FFFFFFF, 32'd1,        0, 4'h8, 32'h80000000, 3'b000, 0);
    apply(32'h2C, 32'h00221827, 32'hF0F0F0F0, 32'h0F0F0000, 0, 4'hC, 32'h00000F0F, 3'b000, 0);
    apply(32'h30, 32'h3822FFFF, 32'hFF00FF00, 32'h0FF00FF0, 0, 4'hA, 32'hF0F0F0F0, 3'b000, 0);
    apply(32'h34, 32'h3022FFFF, 32'hFF00FF00, 32'h0F0F0F0F, 0, 4'h0, 32'h0F000F00, 3'b000, 0);
    apply(32'h38, 32'h3422FFFF, 32'hFF00FF00, 32'h0F0F0F0F, 0, 4'h1, 32'hFF0FFF0F, 3'b000, 0);
    apply(32'h3C, 32'h00221800, 32'd8,        32'd3,        0, 4'h3, 32'h00000300, 3'b000, 0);
    apply(32'h0C, 32'h00221802, 32'd4,        32'h80000000, 0, 4'h4, 32'h08000000, 3'b000, 0);
    // pc 0x104 wraps to word 1
    apply(32'h104, 32'h00221820, 32'hFFFFFFFF, 32'd2,       0, 4'h2, 32'd1,        3'b010, 0);

    // Overwrite the word being fetched; new value visible right after the edge
    imem_we = 1'b1; imem_waddr = IMEM_AW'(1); imem_wdata = 32'h00221825;
    #3;
    chk("fetch_before_write", instruction, 32'h00221820);
    @(posedge CLK); #1;
    imem_we = 1'b0;
    chk("fetch_after_write", instruction, 32'h00221825);
    chk("alu_op_after_write", 32'(alu_op), 32'h1);

    // Asynchronous reset between edges
    #3 Reset_L = 1'b0;
    #1;
    chk("async_reset_result_q", result_q, 32'd0);
    chk("async_reset_flags_q", 32'(flags_q), 32'd0);
    #2 Reset_L = 1'b1;
    @(posedge CLK); #1;
    chk("hold_after_reset", result_q, 32'd0);
    apply(32'h00, 32'h00221820, 32'd5,        32'd7,        0, 4'h2, 32'd12,       3'b000, 0);

    // Unlisted opcode 0x3F executes as ADD
    apply(32'h08, 32'hFC000000, 32'd1,        32'd2,        0, 4'h2, 32'd3,        3'b000, TRAP);

`ifdef ILLEGAL_OP_TRAP_EN
    // Sticky trap: legal instruction now fetched, registers must stay frozen
    pc = 32'h0; bus_a = 32'd100; bus_b = 32'd200; exec_en = 1'b1;
    @(posedge CLK); #1;
    exec_en = 1'b0;
    chk("sticky_illegal", 32'(illegal), 32'd1);
    chk("frozen_result_q", result_q, 32'd3);
    #3 Reset_L = 1'b0;
    #1;
    chk("illegal_cleared", 32'(illegal), 32'd0);
    #2 Reset_L = 1'b1;
`endif

    repeat (3) @(posedge CLK);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
